// File: rtl/seg7_scan_if.sv
// Bus between a seven-segment scan driver and its loopback reader.
// The master side drives seg/an; the slave side reports decoded digits.
interface seg7_scan_if #(
  parameter int NUM_DIGITS = 8
);
  logic [6:0]              seg_in;
  logic [NUM_DIGITS-1:0]   an_in;
  logic [4*NUM_DIGITS-1:0] digits_out;
  logic [NUM_DIGITS-1:0]   digit_valid;
  logic                    change_strobe;
  logic [2:0]              change_index;
  logic                    frame_done;
  logic                    illegal_pulse;
  logic [7:0]              err_count;

  modport master (
    output seg_in, an_in,
    input  digits_out, digit_valid,
    input  change_strobe, change_index,
    input  frame_done, illegal_pulse,
    input  err_count
  );

  modport slave (
    input  seg_in, an_in,
    output digits_out, digit_valid,
    output change_strobe, change_index,
    output frame_done, illegal_pulse,
    output err_count
  );
endinterface

// File: rtl/seg7_scan_reader.sv
// Loopback reader for a multiplexed 7-segment bus: waits for a stable
// seg/an pattern, then decodes it into the nibble of the selected digit.
module seg7_scan_reader #(
  parameter int NUM_DIGITS    = 8,
  parameter int STABLE_CYCLES = 4
) (
  input logic        clk,
  input logic        rst,
  seg7_scan_if.slave bus
);

  localparam int SW = (STABLE_CYCLES > 2) ?
                      $clog2(STABLE_CYCLES) : 1;
  localparam int BW = $clog2(4*NUM_DIGITS);
  localparam logic [SW-1:0] STAB_MAX =
    SW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    CAPTURE,
    HELD
  } state_t;

  state_t                  state;
  logic [NUM_DIGITS-1:0]   s_an;
  logic [6:0]              s_seg;
  logic [NUM_DIGITS-1:0]   cap_an;
  logic [6:0]              cap_seg;
  logic [SW-1:0]           stab;
  logic [NUM_DIGITS-1:0]   mask;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   dvalid;
  logic                    chg;
  logic [2:0]              chg_idx;
  logic                    frame;
  logic                    illegal;
  logic [7:0]              errs;

  function automatic logic an_ok(
    input logic [NUM_DIGITS-1:0] a
  );
    return $countones(~a) == 1;
  endfunction

  function automatic logic [2:0] an_idx(
    input logic [NUM_DIGITS-1:0] a
  );
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (!a[i]) r = 3'(i);
    return r;
  endfunction

  // {illegal, legal numeral, nibble}
  function automatic logic [5:0] decode(
    input logic [6:0] s
  );
    logic [5:0] r;
    case (s)
      7'b1000000: r = {2'b01, 4'h0};
      7'b1111001: r = {2'b01, 4'h1};
      7'b0100100: r = {2'b01, 4'h2};
      7'b0110000: r = {2'b01, 4'h3};
      7'b0011001: r = {2'b01, 4'h4};
      7'b0010010: r = {2'b01, 4'h5};
      7'b0000010: r = {2'b01, 4'h6};
      7'b1111000: r = {2'b01, 4'h7};
      7'b0000000: r = {2'b01, 4'h8};
      7'b0010000: r = {2'b01, 4'h9};
      7'b1111111: r = {2'b00, 4'hF};
      default:    r = {2'b10, 4'hE};
    endcase
    return r;
  endfunction

  logic                  in_ok;
  logic                  s_ok;
  logic                  same_in;
  logic                  same_cap;
  logic [2:0]            cap_idx;
  logic [BW-1:0]         cap_base;
  logic [5:0]            dec;
  logic [3:0]            cur_nib;
  logic [NUM_DIGITS-1:0] cap_oh;
  logic [NUM_DIGITS-1:0] mask_nxt;

  always_comb begin
    in_ok    = an_ok(bus.an_in);
    s_ok     = an_ok(s_an);
    same_in  = ({bus.an_in, bus.seg_in} ==
                {s_an, s_seg});
    same_cap = ({s_an, s_seg} == {cap_an, cap_seg});
    cap_idx  = an_idx(cap_an);
    cap_base = BW'(cap_idx) << 2;
    dec      = decode(cap_seg);
    cur_nib  = digits[cap_base +: 4];
    cap_oh   = '0;
    cap_oh[cap_idx] = 1'b1;
    mask_nxt = mask | cap_oh;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      s_an    <= '1;
      s_seg   <= 7'h7F;
      cap_an  <= '1;
      cap_seg <= 7'h7F;
      stab    <= '0;
      mask    <= '0;
      digits  <= '1;
      dvalid  <= '0;
      chg     <= 1'b0;
      chg_idx <= '0;
      frame   <= 1'b0;
      illegal <= 1'b0;
      errs    <= '0;
    end else begin
      s_an    <= bus.an_in;
      s_seg   <= bus.seg_in;
      chg     <= 1'b0;
      frame   <= 1'b0;
      illegal <= 1'b0;
      if (same_in && in_ok)
        stab <= (stab == STAB_MAX) ?
                stab : stab + 1'b1;
      else
        stab <= '0;
      unique case (state)
        IDLE: begin
          if (s_ok) state <= TRACK;
        end
        TRACK: begin
          if (!s_ok) begin
            state <= IDLE;
          end else if (stab == STAB_MAX) begin
            state   <= CAPTURE;
            cap_an  <= s_an;
            cap_seg <= s_seg;
          end
        end
        CAPTURE: begin
          state                <= HELD;
          digits[cap_base +: 4] <= dec[3:0];
          dvalid[cap_idx]      <= dec[4];
          chg_idx              <= cap_idx;
          chg     <= (dec[3:0] != cur_nib);
          illegal <= dec[5];
          if (dec[5] && errs != 8'hFF)
            errs <= errs + 8'd1;
          if (&mask_nxt) begin
            frame <= 1'b1;
            mask  <= '0;
          end else begin
            mask  <= mask_nxt;
          end
        end
        HELD: begin
          // any movement restarts the stability count
          if (!same_cap) begin
            state <= s_ok ? TRACK : IDLE;
            stab  <= '0;
          end
        end
      endcase
    end
  end

  assign bus.digits_out    = digits;
  assign bus.digit_valid   = dvalid;
  assign bus.change_strobe = chg;
  assign bus.change_index  = chg_idx;
  assign bus.frame_done    = frame;
  assign bus.illegal_pulse = illegal;
  assign bus.err_count     = errs;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Directed bench for seg7_scan_reader: latency, loopback
// sequence, frame scan, illegal/saturation, glitch, reset.
module tb_seg7_scan_reader;

  logic clk = 1'b0;
  logic rst = 1'b1;

  seg7_scan_if #(.NUM_DIGITS(8)) bus();

  seg7_scan_reader #(
    .NUM_DIGITS(8),
    .STABLE_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;

  int n_chg = 0;
  int n_frm = 0;
  int n_ill = 0;
  logic [2:0] frm_idx = '0;
  logic [3:0] log_q[$];

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      default: return 7'b0010000;
    endcase
  endfunction

  always @(negedge clk) begin
    if (bus.change_strobe) begin
      n_chg++;
      log_q.push_back(
        bus.digits_out[bus.change_index*4 +: 4]);
    end
    if (bus.frame_done) begin
      n_frm++;
      frm_idx = bus.change_index;
    end
    if (bus.illegal_pulse) n_ill++;
  end

  task automatic drive(
    input logic [7:0] a,
    input logic [6:0] s,
    input int         n
  );
    bus.an_in  = a;
    bus.seg_in = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    bus.an_in  = 8'hFF;
    bus.seg_in = 7'h7F;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    int hits, edge_at, c0, f0, i0, q0;
    logic [31:0] dsnap;
    logic [7:0]  an_v;

    bus.an_in  = 8'hFF;
    bus.seg_in = 7'h7F;
    do_reset();

    check("rst_digits", bus.digits_out, 32'hFFFF_FFFF);
    check("rst_valid", bus.digit_valid, 0);
    check("rst_err", bus.err_count, 0);
    check("rst_pulses", {bus.change_strobe,
          bus.frame_done, bus.illegal_pulse}, 0);

    // T1: latency of a single stable pattern
    bus.an_in  = 8'b0111_1111;
    bus.seg_in = 7'b0100100;
    hits = 0;
    edge_at = -1;
    for (int e = 0; e < 10; e++) begin
      @(posedge clk);
      #1;
      if (bus.change_strobe) begin
        hits++;
        edge_at = e;
      end
    end
    check("t1_strobes", hits, 1);
    check("t1_edge", edge_at, 5);
    check("t1_nib7", bus.digits_out[31:28], 4'h2);
    check("t1_valid7", bus.digit_valid[7], 1'b1);
    check("t1_index", bus.change_index, 3'd7);
    @(negedge clk);

    // T2: counter loopback on digit 7
    settle();
    c0 = n_chg;
    f0 = n_frm;
    q0 = log_q.size();
    for (int k = 0; k < 6; k++)
      drive(8'b0111_1111, seg_of(k % 5), 20);
    settle();
    check("t2_strobes", n_chg - c0, 6);
    for (int k = 0; k < 6; k++) begin
      if (q0 + k < log_q.size())
        check($sformatf("t2_seq%0d", k),
              log_q[q0+k], 4'(k % 5));
      else
        check($sformatf("t2_seq%0d", k), 32'hDEAD, 4'(k % 5));
    end
    check("t2_err", bus.err_count, 0);
    check("t2_frames", n_frm - f0, 0);

    // T3: full scan of all digits
    do_reset();
    settle();
    f0 = n_frm;
    for (int d = 0; d < 8; d++) begin
      an_v    = 8'hFF;
      an_v[d] = 1'b0;
      drive(an_v, seg_of(d), 8);
    end
    settle();
    check("t3_frames", n_frm - f0, 1);
    check("t3_frm_idx", frm_idx, 3'd7);
    check("t3_digits", bus.digits_out, 32'h7654_3210);
    check("t3_valid", bus.digit_valid, 8'hFF);

    // T4: illegal pattern and error saturation
    settle();
    i0 = n_ill;
    drive(8'b1111_0111, 7'b0000001, 8);
    settle();
    check("t4_nib3", bus.digits_out[15:12], 4'hE);
    check("t4_valid3", bus.digit_valid[3], 1'b0);
    check("t4_ill", n_ill - i0, 1);
    check("t4_err1", bus.err_count, 1);
    for (int k = 0; k < 300; k++)
      drive(8'b1111_0111,
            (k % 2 == 0) ? 7'b0000011 : 7'b0000001, 8);
    settle();
    check("t4_err_sat", bus.err_count, 8'hFF);
    check("t4_ill_all", n_ill - i0, 301);

    // T5: glitch rejection and two low anodes
    drive(8'b1101_1111, seg_of(3), 10);
    settle();
    check("t5_nib5", bus.digits_out[23:20], 4'h3);
    c0 = n_chg;
    i0 = n_ill;
    drive(8'b1101_1111, seg_of(1), 2);
    drive(8'b1101_1111, seg_of(3), 10);
    settle();
    check("t5_glitch_chg", n_chg - c0, 0);
    check("t5_glitch_nib", bus.digits_out[23:20], 4'h3);
    dsnap = bus.digits_out;
    drive(8'b1101_1011, seg_of(8), 12);
    settle();
    check("t5_dual_chg", n_chg - c0, 0);
    check("t5_dual_ill", n_ill - i0, 0);
    check("t5_dual_dig", bus.digits_out, dsnap);

    // T6: reset while tracking
    drive(8'b1111_1101, seg_of(1), 3);
    #2 rst = 1'b1;
    #1;
    check("t6_digits", bus.digits_out, 32'hFFFF_FFFF);
    check("t6_valid", bus.digit_valid, 0);
    check("t6_err", bus.err_count, 0);
    check("t6_index", bus.change_index, 0);
    check("t6_pulses", {bus.change_strobe,
          bus.frame_done, bus.illegal_pulse}, 0);
    @(negedge clk);
    rst = 1'b0;
    hits = 0;
    edge_at = -1;
    for (int e = 0; e < 10; e++) begin
      @(posedge clk);
      #1;
      if (bus.change_strobe) begin
        hits++;
        edge_at = e;
      end
    end
    check("t6_re_strobes", hits, 1);
    check("t6_re_edge", edge_at, 5);
    check("t6_re_nib1", bus.digits_out[7:4], 4'h1);

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
